mem_arbiter: RTL and testbench

Arbiter that shares the single main-memory port between the instruction cache and the data cache. Both caches see a private line-granular memory port. The block serialises their misses and write-backs onto one 256-bit memory bus, one transaction at a time, with round-robin fairness. It sits between the two cache controllers' memory-side signals and the main memory model or controller.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// mem_arbiter_pkg -- shared sizes and state/grant types for the I/D memory arbiter.  Rev 1.0
package mem_arbiter_pkg;
   localparam int LINE_W      = 256;
   localparam int ADDR_W      = 32;
   localparam int OFFSET_BITS = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      DONE    = 2'd3
   } arb_state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;
endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter -- round-robin arbiter sharing one line-wide memory port between icache and dcache.
// Rev 1.0
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int LINE_W = mem_arbiter_pkg::LINE_W,
   parameter int ADDR_W = mem_arbiter_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   localparam logic [ADDR_W-1:0] LINE_MASK =
      {{(ADDR_W-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

   arb_state_t        state, state_nxt;
   grant_t            owner, owner_nxt;
   grant_t            last_grant, last_grant_nxt;
   logic              op_write, op_write_nxt;
   logic [LINE_W-1:0] line_buf, line_buf_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [LINE_W-1:0] mem_wdata_nxt;
   logic              mem_read_nxt, mem_write_nxt;
   logic              i_resp_nxt, d_resp_nxt;
   logic [LINE_W-1:0] i_rdata_nxt, d_rdata_nxt;

   logic              want_i, want_d, pick_d;
   logic [ADDR_W-1:0] i_line_addr, d_line_addr;

   assign want_i      = i_read;
   assign want_d      = d_read | d_write;
   // Dcache wins when alone, or on contention when icache had the last contended grant.
   assign pick_d      = want_d & (~want_i | (last_grant == GRANT_I));
   assign i_line_addr = i_addr & LINE_MASK;
   assign d_line_addr = d_addr & LINE_MASK;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= GRANT_I;
         last_grant <= GRANT_I;
         op_write   <= 1'b0;
         line_buf   <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         i_resp     <= 1'b0;
         d_resp     <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_grant <= last_grant_nxt;
         op_write   <= op_write_nxt;
         line_buf   <= line_buf_nxt;
         mem_addr   <= mem_addr_nxt;
         mem_wdata  <= mem_wdata_nxt;
         mem_read   <= mem_read_nxt;
         mem_write  <= mem_write_nxt;
         i_resp     <= i_resp_nxt;
         d_resp     <= d_resp_nxt;
         i_rdata    <= i_rdata_nxt;
         d_rdata    <= d_rdata_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_grant_nxt = last_grant;
      op_write_nxt   = op_write;
      line_buf_nxt   = line_buf;
      mem_addr_nxt   = mem_addr;
      mem_wdata_nxt  = mem_wdata;
      mem_read_nxt   = mem_read;
      mem_write_nxt  = mem_write;
      i_resp_nxt     = 1'b0;
      d_resp_nxt     = 1'b0;
      i_rdata_nxt    = '0;
      d_rdata_nxt    = '0;

      case (state)
         IDLE: begin
            if (pick_d) begin
               state_nxt     = SERVE_D;
               owner_nxt     = GRANT_D;
               op_write_nxt  = d_write;
               mem_addr_nxt  = d_line_addr;
               mem_wdata_nxt = d_wdata;
               mem_write_nxt = d_write;
               mem_read_nxt  = ~d_write;
               if (want_i) last_grant_nxt = GRANT_D;
            end else if (want_i) begin
               state_nxt     = SERVE_I;
               owner_nxt     = GRANT_I;
               op_write_nxt  = 1'b0;
               mem_addr_nxt  = i_line_addr;
               mem_wdata_nxt = '0;
               mem_read_nxt  = 1'b1;
               mem_write_nxt = 1'b0;
               if (want_d) last_grant_nxt = GRANT_I;
            end
         end
         SERVE_I, SERVE_D: begin
            if (mem_resp) begin
               state_nxt     = DONE;
               mem_read_nxt  = 1'b0;
               mem_write_nxt = 1'b0;
               if (!op_write) line_buf_nxt = mem_rdata;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            if (owner == GRANT_I) begin
               i_resp_nxt  = 1'b1;
               i_rdata_nxt = line_buf;
            end else begin
               d_resp_nxt  = 1'b1;
               d_rdata_nxt = line_buf;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter -- randomized bench checking mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int LW = 256;
   localparam int AW = 32;
   localparam logic [AW-1:0] MASK = 32'hFFFF_FFE0;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_read, d_read, d_write, mem_resp;
   logic [AW-1:0] i_addr, d_addr;
   logic [LW-1:0] d_wdata, mem_rdata;
   logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
   logic          i_resp, d_resp, mem_read, mem_write;
   logic [AW-1:0] mem_addr;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: pending requests per cache and the owner of the last contended grant.
   bit            pend_i, pend_d, d_wr;
   logic [AW-1:0] ia, da;
   logic [LW-1:0] dw;
   grant_t        last_cont;
   int            hold_used;

   task automatic check_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic check_quiet(input string tag);
      check_val({tag, ".mem_read"},  mem_read,  0);
      check_val({tag, ".mem_write"}, mem_write, 0);
      check_val({tag, ".i_resp"},    i_resp,    0);
      check_val({tag, ".d_resp"},    d_resp,    0);
      check_val({tag, ".i_rdata"},   i_rdata,   0);
      check_val({tag, ".d_rdata"},   d_rdata,   0);
   endtask

   task automatic serve_one();
      grant_t        w;
      bit            exp_wr, dropped;
      logic [AW-1:0] exp_a;
      logic [LW-1:0] rd;
      int            lat;
      if (pend_i && pend_d) begin
         w = (last_cont == GRANT_I) ? GRANT_D : GRANT_I;
         last_cont = w;
      end else begin
         w = pend_d ? GRANT_D : GRANT_I;
      end
      exp_wr = (w == GRANT_D) && d_wr;
      exp_a  = ((w == GRANT_D) ? da : ia) & MASK;
      tick();
      check_val("grant.mem_read",  mem_read,  !exp_wr);
      check_val("grant.mem_write", mem_write, exp_wr);
      check_val("grant.mem_addr",  mem_addr,  exp_a);
      if (exp_wr) check_val("grant.mem_wdata", mem_wdata, dw);
      check_val("grant.i_resp", i_resp, 0);
      check_val("grant.d_resp", d_resp, 0);
      dropped = ($urandom_range(0, 3) == 0);
      if (dropped) begin
         if (w == GRANT_I) begin i_read = 0; i_addr = $urandom; end
         else begin d_read = 0; d_write = 0; d_addr = $urandom; d_wdata = rand_line(); end
      end
      lat = $urandom_range(1, 4);
      rd  = rand_line();
      for (int c = 1; c <= lat; c++) begin
         if (c > 1) begin
            check_val("serve.mem_read",  mem_read,  !exp_wr);
            check_val("serve.mem_write", mem_write, exp_wr);
            check_val("serve.mem_addr",  mem_addr,  exp_a);
            if (exp_wr) check_val("serve.mem_wdata", mem_wdata, dw);
            check_val("serve.resp", {i_resp, d_resp}, 0);
         end
         mem_resp  = (c == lat);
         mem_rdata = (c == lat) ? rd : rand_line();
         tick();
      end
      mem_resp  = $urandom_range(0, 1);
      mem_rdata = rand_line();
      check_quiet("done");
      tick();
      mem_resp = 0;
      check_val("resp.mem_cmd", {mem_read, mem_write}, 0);
      check_val("resp.i_resp", i_resp, w == GRANT_I);
      check_val("resp.d_resp", d_resp, w == GRANT_D);
      if (w == GRANT_I) begin
         check_val("resp.i_rdata", i_rdata, rd);
         check_val("resp.d_rdata_other", d_rdata, 0);
      end else begin
         if (!exp_wr) check_val("resp.d_rdata", d_rdata, rd);
         check_val("resp.i_rdata_other", i_rdata, 0);
      end
      if (!dropped && hold_used == 0 && $urandom_range(0, 2) == 0) begin
         hold_used = 1;
      end else if (w == GRANT_I) begin
         pend_i = 0; i_read = 0;
      end else begin
         pend_d = 0; d_read = 0; d_write = 0;
      end
   endtask

   task automatic serve_all();
      int guard = 0;
      hold_used = 0;
      while ((pend_i || pend_d) && guard < 8) begin
         guard++;
         serve_one();
      end
      tick();
      check_quiet("idle");
   endtask

   task automatic start_round(input bit want_i, input int d_op);
      pend_i = want_i;
      pend_d = (d_op != 0);
      d_wr   = (d_op >= 2);
      ia = $urandom; da = $urandom; dw = rand_line();
      i_read = want_i; i_addr = ia;
      d_read = (d_op == 1 || d_op == 3); d_write = d_wr; d_addr = da; d_wdata = dw;
      serve_all();
   endtask

   initial begin
      rst = 1; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
      i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
      last_cont = GRANT_I;
      repeat (2) @(posedge clk);
      #1;
      check_quiet("reset");
      check_val("reset.mem_addr",  mem_addr,  0);
      check_val("reset.mem_wdata", mem_wdata, 0);
      rst = 0;
      tick();
      check_quiet("post_reset");

      // Contention right after reset goes to dcache, the next one to icache.
      start_round(1, 1);
      start_round(1, 1);
      start_round(1, 0);
      start_round(0, 2);
      start_round(1, 3);

      for (int r = 0; r < 60; r++) begin
         int di;
         bit wi;
         wi = $urandom_range(0, 1);
         di = $urandom_range(0, 3);
         if (!wi && di == 0) di = 1;
         start_round(wi, di);
         repeat ($urandom_range(0, 2)) begin
            mem_resp = $urandom_range(0, 1);
            tick();
            mem_resp = 0;
            check_quiet("gap");
         end
      end

      // Asynchronous reset in the middle of an icache fill.
      i_read = 1; i_addr = $urandom;
      tick();
      check_val("abort.mem_read", mem_read, 1);
      tick();
      #2 rst = 1;
      #1;
      check_quiet("abort");
      check_val("abort.mem_addr", mem_addr, 0);
      i_read = 0;
      tick();
      rst = 0;
      repeat (3) begin
         tick();
         check_quiet("after_abort");
      end
      last_cont = GRANT_I;
      start_round(1, 0);
      start_round(1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
